// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared width, FSM state type and id-width helper for the divider scheduler.
`default_nettype none
package div_sched_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // ceil(log2(n)), never below 1 so a 2-requester id still has a bit
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage
`default_nettype wire

// File: rtl/div.sv
// div: iterative 32-bit unsigned restoring divider, 32 cycles after en, single-cycle done pulse.
// A zero divisor never raises done; the next en re-arms the unit.
`default_nettype none
module div (
  input  logic        clk,
  input  logic        en,
  input  logic [31:0] y,
  input  logic [31:0] x,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        done
);
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_den;
  logic [5:0]  r_cnt;
  logic        r_run;
  logic [32:0] w_sh;
  logic [31:0] w_sub;
  logic        w_ge;

  assign w_sh  = {r_rem, r_quo[31]};
  assign w_ge  = (w_sh >= {1'b0, r_den});
  // the true difference is below the divisor, so 32 bits suffice
  assign w_sub = w_sh[31:0] - r_den;

  always_ff @(posedge clk) begin
    if (en) begin
      r_quo <= y;
      r_rem <= '0;
      r_den <= x;
      r_cnt <= 6'd32;
      r_run <= (x != '0);
      done  <= 1'b0;
    end else if (r_run) begin
      r_quo <= {r_quo[30:0], w_ge};
      r_rem <= w_ge ? w_sub : w_sh[31:0];
      r_cnt <= r_cnt - 6'd1;
      r_run <= (r_cnt != 6'd1);
      done  <= (r_cnt == 6'd1);
    end else begin
      done  <= 1'b0;
    end
  end

  assign q = r_quo;
  assign r = r_rem;
endmodule
`default_nettype wire

// File: rtl/div_sched_rr_pick.sv
// div_rr_pick: combinational round-robin picker, first request after i_ptr (wrapping) wins.
`default_nettype none
module div_rr_pick
  import div_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic            o_any,
  output logic [ID_W-1:0] o_win
);
  // scan farthest-first so the nearest candidate after the pointer is written last
  always_comb begin
    o_any = 1'b0;
    o_win = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (i_req[(int'(i_ptr) + k) % NREQ]) begin
        o_any = 1'b1;
        o_win = ID_W'((int'(i_ptr) + k) % NREQ);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one iterative divider among NREQ requesters.
// Optional: DIV_BY_ZERO_CHECK_EN answers zero divisors directly without using the divider.
`default_nettype none
module div_sched
  import div_sched_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 80,
  localparam int ID_W    = clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*DATA_W-1:0] i_dividend,
  input  logic [NREQ*DATA_W-1:0] i_divisor,
  output logic [NREQ-1:0]        o_ack,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic [DATA_W-1:0]      o_rsp_q,
  output logic [DATA_W-1:0]      o_rsp_r,
  output logic                   o_rsp_err,
  output logic                   o_busy
);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [NREQ-1:0]     r_ack;
  logic [DATA_W-1:0]   r_y;
  logic [DATA_W-1:0]   r_x;
  logic                r_valid;
  logic [DATA_W-1:0]   r_q;
  logic [DATA_W-1:0]   r_r;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_any;
  logic [ID_W-1:0]     w_win;
  logic [DATA_W-1:0]   w_win_y;
  logic [DATA_W-1:0]   w_win_x;
  logic                w_zero;
  logic                w_tmo;
  logic                w_div_en;
  logic                w_div_done;
  logic [DATA_W-1:0]   w_div_q;
  logic [DATA_W-1:0]   w_div_r;

  div_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_win (w_win)
  );

  div u_div (
    .clk  (clk),
    .en   (w_div_en),
    .y    (r_y),
    .x    (r_x),
    .q    (w_div_q),
    .r    (w_div_r),
    .done (w_div_done)
  );

  assign w_win_y = i_dividend[int'(w_win) * DATA_W +: DATA_W];
  assign w_win_x = i_divisor[int'(w_win) * DATA_W +: DATA_W];
  assign w_tmo   = (r_cnt == CNT_W'(TIMEOUT - 1));

`ifdef DIV_BY_ZERO_CHECK_EN
  assign w_zero = (w_win_x == '0);
`else
  assign w_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = w_zero ? RESP : LOAD;
      LOAD:    w_next = WAIT;
      WAIT:    if (w_div_done || w_tmo) w_next = RESP;
      RESP:    if (r_valid && i_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_div_en = (r_state == LOAD);
    o_busy   = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= ID_W'(NREQ - 1);
      r_id    <= '0;
      r_ack   <= '0;
      r_y     <= '0;
      r_x     <= '0;
      r_valid <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ptr <= w_win;
            r_id  <= w_win;
            r_y   <= w_win_y;
            r_x   <= w_win_x;
            r_ack <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
`ifdef DIV_BY_ZERO_CHECK_EN
            if (w_zero) begin
              r_q     <= '1;
              r_r     <= w_win_y;
              r_err   <= 1'b1;
              r_valid <= 1'b1;
            end
`endif
          end
        end
        LOAD: r_cnt <= '0;
        WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // a done arriving on the timeout cycle still delivers the real result
          if (w_div_done) begin
            r_q     <= w_div_q;
            r_r     <= w_div_r;
            r_err   <= 1'b0;
            r_valid <= 1'b1;
          end else if (w_tmo) begin
            r_q     <= '0;
            r_r     <= '0;
            r_err   <= 1'b1;
            r_valid <= 1'b1;
          end
        end
        RESP: if (r_valid && i_rsp_ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_ack       = r_ack;
  assign o_rsp_valid = r_valid;
  assign o_rsp_id    = r_id;
  assign o_rsp_q     = r_q;
  assign o_rsp_r     = r_r;
  assign o_rsp_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_div_sched.sv
// tb_div_sched: table vectors, corner-case sequences and randomized traffic against a reference model.
`default_nettype none
module tb_div_sched;
  import div_sched_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 80;
  localparam int ID_W    = clog2(NREQ);

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        i_req = '0;
  logic [NREQ*DATA_W-1:0] i_dividend = '0;
  logic [NREQ*DATA_W-1:0] i_divisor = '0;
  logic [NREQ-1:0]        o_ack;
  logic                   o_rsp_valid;
  logic                   i_rsp_ready = 1'b0;
  logic [ID_W-1:0]        o_rsp_id;
  logic [DATA_W-1:0]      o_rsp_q;
  logic [DATA_W-1:0]      o_rsp_r;
  logic                   o_rsp_err;
  logic                   o_busy;

  div_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_ack       (o_ack),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_q     (o_rsp_q),
    .o_rsp_r     (o_rsp_r),
    .o_rsp_err   (o_rsp_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int model_ptr = NREQ - 1;
  int cyc = 0;
  int en_seen = 0;
  logic [31:0] op_y [NREQ];
  logic [31:0] op_x [NREQ];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.w_div_en) en_seen <= en_seen + 1;
  end

  typedef struct {
    int          id;
    logic [31:0] y;
    logic [31:0] x;
    logic [31:0] q;
    logic [31:0] r;
    logic        err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference arbitration: first requester after the last winner, wrapping
  function automatic int model_pick(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++)
      if (mask[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic set_ops(input int id, input logic [31:0] y, input logic [31:0] x);
    op_y[id] = y;
    op_x[id] = x;
    i_dividend[id*32 +: 32] = y;
    i_divisor[id*32 +: 32]  = x;
  endtask

  task automatic wait_ack(output int win, output int lat);
    win = -1;
    lat = 0;
    while (win < 0 && lat < 20) begin
      tick();
      lat++;
      if (o_ack != '0) begin
        check("ack_onehot", 64'($onehot(o_ack)), 64'd1);
        for (int i = 0; i < NREQ; i++) if (o_ack[i]) win = i;
      end
    end
    if (win < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL ack_wait: no ack within %0d cycles, required one", lat);
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!o_rsp_valid && lat < 400) begin
      tick();
      lat++;
    end
    if (!o_rsp_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL rsp_wait: rsp_valid low after %0d cycles, required high", lat);
    end
  endtask

  task automatic check_rsp(input string tag, input int id, input logic [31:0] q,
                           input logic [31:0] r, input logic err);
    check({tag, "_id"},  o_rsp_id, id);
    check({tag, "_q"},   o_rsp_q, q);
    check({tag, "_r"},   o_rsp_r, r);
    check({tag, "_err"}, o_rsp_err, err);
  endtask

  task automatic check_model(input string tag, input int id);
    if (op_x[id] == 0) begin
`ifdef DIV_BY_ZERO_CHECK_EN
      check_rsp(tag, id, 32'hFFFF_FFFF, op_y[id], 1'b1);
`else
      check_rsp(tag, id, 32'h0, 32'h0, 1'b1);
`endif
    end else begin
      check_rsp(tag, id, op_y[id] / op_x[id], op_y[id] % op_x[id], 1'b0);
    end
  endtask

  task automatic handshake(input string tag);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    check({tag, "_drop"}, o_rsp_valid, 1'b0);
  endtask

  task automatic single(input string tag, input vec_t v);
    int win, lat;
    set_ops(v.id, v.y, v.x);
    i_req[v.id] = 1'b1;
    wait_ack(win, lat);
    check({tag, "_acklat"}, lat, 1);
    check({tag, "_ackid"}, win, v.id);
    i_req = '0;
    model_ptr = v.id;
    wait_rsp(lat);
    check_rsp(tag, v.id, v.q, v.r, v.err);
    handshake(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_ptr = NREQ - 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt [7];
    int win, lat, ack_cyc, exp_w;
    logic stable;

    vt[0] = '{0, 32'd100,        32'd7,          32'd14,         32'd2,   1'b0};
    vt[1] = '{1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,   1'b0};
    vt[2] = '{2, 32'd5,          32'd9,          32'd0,          32'd5,   1'b0};
    vt[3] = '{3, 32'h8000_0000,  32'h0001_0000,  32'h0000_8000,  32'd0,   1'b0};
    vt[4] = '{1, 32'd12345678,   32'd1000,       32'd12345,      32'd678, 1'b0};
    vt[5] = '{2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,   1'b0};
    vt[6] = '{0, 32'd1000,       32'd7,          32'd142,        32'd6,   1'b0};

    for (int i = 0; i < NREQ; i++) set_ops(i, 32'd0, 32'd1);
    repeat (3) tick();
    check("rst_ack", o_ack, 0);
    check("rst_valid", o_rsp_valid, 0);
    check("rst_id", o_rsp_id, 0);
    check("rst_q", o_rsp_q, 0);
    check("rst_r", o_rsp_r, 0);
    check("rst_err", o_rsp_err, 0);
    check("rst_busy", o_busy, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) single($sformatf("vec%0d", i), vt[i]);

    // all requesters held: grants rotate 0,1,2,3,0 from reset
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'd1000 + 32'(i * 37), 32'd3 + 32'(i));
    i_req = '1;
    i_rsp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_ack(win, lat);
      check($sformatf("rr_grant%0d", g), win, g % NREQ);
      exp_w = model_pick(i_req);
      model_ptr = exp_w;
      wait_rsp(lat);
      if (g == 4) i_req = '0;
      check_model($sformatf("rr_rsp%0d", g), exp_w);
    end
    tick();
    i_rsp_ready = 1'b0;
    check("rr_idle", o_busy, 0);

    // backpressure: result held 20 cycles, competing request waits for handshake+1
    set_ops(1, 32'd999, 32'd10);
    i_req[1] = 1'b1;
    wait_ack(win, lat);
    i_req = '0;
    model_ptr = 1;
    wait_rsp(lat);
    set_ops(2, 32'd50, 32'd5);
    i_req[2] = 1'b1;
    stable = 1'b1;
    repeat (20) begin
      if (!o_rsp_valid || o_rsp_q != 32'd99 || o_rsp_r != 32'd9 || o_rsp_id != 1 ||
          o_rsp_err || o_ack != '0) stable = 1'b0;
      tick();
    end
    check("bp_stable", stable, 1'b1);
    check_rsp("bp_rsp", 1, 32'd99, 32'd9, 1'b0);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    check("bp_noack_idle", o_ack, 0);
    tick();
    check("bp_ack_next", o_ack, 4'b0100);
    i_req = '0;
    model_ptr = 2;
    wait_rsp(lat);
    check_rsp("bp_rsp2", 2, 32'd10, 32'd0, 1'b0);
    handshake("bp");

    // zero divisor: timeout in the default build, direct error response with the check enabled
    set_ops(3, 32'd55, 32'd0);
    en_seen = 0;
    i_req[3] = 1'b1;
    wait_ack(win, lat);
    ack_cyc = cyc;
    i_req = '0;
    model_ptr = 3;
    wait_rsp(lat);
`ifdef DIV_BY_ZERO_CHECK_EN
    check("dbz_lat", cyc - ack_cyc, 0);
    check("dbz_no_en", en_seen, 0);
    check_rsp("dbz", 3, 32'hFFFF_FFFF, 32'd55, 1'b1);
`else
    // ack is seen in the LOAD cycle; TIMEOUT WAIT cycles follow before rsp_valid
    check("tmo_lat", cyc - ack_cyc, TIMEOUT + 1);
    check_rsp("tmo", 3, 32'd0, 32'd0, 1'b1);
`endif
    handshake("zero");

    // randomized masks and operands against the reference model
    for (int t = 0; t < 30; t++) begin
      logic [NREQ-1:0] mask;
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        logic [31:0] x;
        x = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
        if (x == 0) x = 32'd1;
        set_ops(i, $urandom, x);
      end
      exp_w = model_pick(mask);
      i_req = mask;
      wait_ack(win, lat);
      check($sformatf("rnd%0d_win", t), win, exp_w);
      i_req = '0;
      model_ptr = exp_w;
      wait_rsp(lat);
      check_model($sformatf("rnd%0d", t), exp_w);
      handshake($sformatf("rnd%0d", t));
    end

    // reset during WAIT clears outputs at once; the next request completes normally
    single("pre_rst", vt[0]);
    set_ops(2, 32'd1000, 32'd3);
    i_req[2] = 1'b1;
    wait_ack(win, lat);
    i_req = '0;
    repeat (5) tick();
    check("mid_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_ack", o_ack, 0);
    check("mrst_valid", o_rsp_valid, 0);
    check("mrst_id", o_rsp_id, 0);
    check("mrst_q", o_rsp_q, 0);
    check("mrst_r", o_rsp_r, 0);
    check("mrst_err", o_rsp_err, 0);
    check("mrst_busy", o_busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    model_ptr = NREQ - 1;
    single("post_rst", '{3, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
